// File: rtl/ps2_key_decoder.sv
// PS/2 receiver + set-2 arrow decoder; WASD_EN adds W/S/D/A as alternate key sources.
// Latency: pin edge to fall cycle SYNC_STAGES+1 clks, outputs 1 clk after stop-bit fall. No backpressure.
module ps2_key_decoder #(
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 10000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] scan_code,
   output logic       scan_valid,
   output logic       frame_err,
   output logic       up,
   output logic       down,
   output logic       right,
   output logic       left
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   // Synchronisers start at 1 so leaving reset looks like an idle bus.
   logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
   logic                   clk_prev_q;
   logic                   clk_s, data_s, fall;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         clk_sync_q  <= '1;
         data_sync_q <= '1;
         clk_prev_q  <= 1'b1;
      end else begin
         clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
         data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
         clk_prev_q  <= clk_s;
      end
   end

   assign clk_s  = clk_sync_q[SYNC_STAGES-1];
   assign data_s = data_sync_q[SYNC_STAGES-1];
   assign fall   = clk_prev_q & ~clk_s;

   state_t          state_q, state_d;
   logic [2:0]      bit_cnt_q, bit_cnt_d;
   logic [7:0]      shift_q, shift_d;
   logic            par_q, par_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic [7:0]      scan_code_q, scan_code_d;
   logic            scan_valid_q, scan_valid_d;
   logic            frame_err_q, frame_err_d;

   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      par_d        = par_q;
      scan_code_d  = scan_code_q;
      scan_valid_d = 1'b0;
      frame_err_d  = 1'b0;
      tmo_d        = (state_q == IDLE || fall) ? '0 : tmo_q + TW'(1);

      unique case (state_q)
         IDLE: begin
            if (fall && !data_s) begin
               state_d   = DATA;
               bit_cnt_d = '0;
            end
         end
         DATA: begin
            if (fall) begin
               shift_d   = {data_s, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) state_d = PARITY;
            end
         end
         PARITY: begin
            if (fall) begin
               par_d   = data_s;
               state_d = STOP;
            end
         end
         STOP: begin
            if (fall) begin
               state_d = IDLE;
               if (data_s && (^{shift_q, par_q})) begin
                  scan_code_d  = shift_q;
                  scan_valid_d = 1'b1;
               end else begin
                  frame_err_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // A fall always restarts the timer, so a stop-bit fall can never collide with a timeout.
      if (state_q != IDLE && !fall && tmo_q == TMO_LAST) begin
         state_d     = IDLE;
         frame_err_d = 1'b1;
         tmo_d       = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         par_q        <= 1'b0;
         tmo_q        <= '0;
         scan_code_q  <= '0;
         scan_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         par_q        <= par_d;
         tmo_q        <= tmo_d;
         scan_code_q  <= scan_code_d;
         scan_valid_q <= scan_valid_d;
         frame_err_q  <= frame_err_d;
      end
   end

   // Key state vectors are ordered {up, down, right, left}.
   logic       ext_q, ext_d, brk_q, brk_d;
   logic [3:0] arrow_q, arrow_d;
   logic [3:0] letter_q, letter_d;

   always_comb begin
      ext_d    = ext_q;
      brk_d    = brk_q;
      arrow_d  = arrow_q;
      letter_d = letter_q;
      if (frame_err_q) begin
         ext_d = 1'b0;
         brk_d = 1'b0;
      end else if (scan_valid_q) begin
         if (scan_code_q == 8'hE0) begin
            ext_d = 1'b1;
         end else if (scan_code_q == 8'hF0) begin
            brk_d = 1'b1;
         end else begin
            if (ext_q) begin
               case (scan_code_q)
                  8'h75:   arrow_d[3] = !brk_q;
                  8'h72:   arrow_d[2] = !brk_q;
                  8'h74:   arrow_d[1] = !brk_q;
                  8'h6B:   arrow_d[0] = !brk_q;
                  default: ;
               endcase
            end
`ifdef WASD_EN
            else begin
               case (scan_code_q)
                  8'h1D:   letter_d[3] = !brk_q;
                  8'h1B:   letter_d[2] = !brk_q;
                  8'h23:   letter_d[1] = !brk_q;
                  8'h1C:   letter_d[0] = !brk_q;
                  default: ;
               endcase
            end
`endif
            ext_d = 1'b0;
            brk_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ext_q    <= 1'b0;
         brk_q    <= 1'b0;
         arrow_q  <= '0;
         letter_q <= '0;
      end else begin
         ext_q    <= ext_d;
         brk_q    <= brk_d;
         arrow_q  <= arrow_d;
         letter_q <= letter_d;
      end
   end

   assign scan_code  = scan_code_q;
   assign scan_valid = scan_valid_q;
   assign frame_err  = frame_err_q;
   assign up         = arrow_q[3] | letter_q[3];
   assign down       = arrow_q[2] | letter_q[2];
   assign right      = arrow_q[1] | letter_q[1];
   assign left       = arrow_q[0] | letter_q[0];

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: frames are queued with their expected outcome, a monitor checks each pulse.
module tb_ps2_key_decoder;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic [7:0] scan_code;
   logic       scan_valid, frame_err, up, down, right, left;

   ps2_key_decoder #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(10000)) dut (
      .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .scan_code(scan_code), .scan_valid(scan_valid), .frame_err(frame_err),
      .up(up), .down(down), .right(right), .left(left)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       is_err;
      logic [7:0] code;
      logic [3:0] keys;
   } exp_t;

   exp_t exp_q[$];
   int   passed = 0;
   int   total  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Reference model: held keys per source, prefix flags, last good byte.
   bit         m_ext, m_brk;
   bit [3:0]   m_arrow, m_letter;
   logic [7:0] m_last;

   function automatic int key_index(input logic [7:0] b, input bit letter);
      logic [7:0] tbl[4];
      if (letter) tbl = '{8'h1D, 8'h1B, 8'h23, 8'h1C};
      else        tbl = '{8'h75, 8'h72, 8'h74, 8'h6B};
      for (int i = 0; i < 4; i++) if (tbl[i] == b) return 3 - i;
      return -1;
   endfunction

   task automatic model_byte(input logic [7:0] b);
      int k;
      if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_brk = 1;
      else begin
         if (m_ext) begin
            k = key_index(b, 0);
            if (k >= 0) m_arrow[k] = !m_brk;
         end else begin
`ifdef WASD_EN
            k = key_index(b, 1);
            if (k >= 0) m_letter[k] = !m_brk;
`endif
         end
         m_ext = 0;
         m_brk = 0;
      end
   endtask

   task automatic push_err();
      m_ext = 0;
      m_brk = 0;
      exp_q.push_back('{is_err: 1'b1, code: m_last, keys: m_arrow | m_letter});
   endtask

   task automatic ps2_bit(input logic v);
      @(negedge clk);
      ps2_data = v;
      repeat (10) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (20) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (10) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
      logic [10:0] bits;
      logic        par;
      par  = ~(^b) ^ bad_par;
      bits = {~bad_stop, par, b, 1'b0};
      if (bad_par || bad_stop) push_err();
      else begin
         m_last = b;
         model_byte(b);
         exp_q.push_back('{is_err: 1'b0, code: b, keys: m_arrow | m_letter});
      end
      for (int i = 0; i < 11; i++) ps2_bit(bits[i]);
      ps2_data = 1'b1;
      repeat (30) @(negedge clk);
   endtask

   task automatic send_seq(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input int n);
      send_frame(a, 0, 0);
      if (n > 1) send_frame(b, 0, 0);
      if (n > 2) send_frame(c, 0, 0);
   endtask

   // Monitor: every pulse must match the head of the queue; keys checked the cycle after.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset && (scan_valid || frame_err)) begin
            chk("pulse_exclusive", {31'd0, scan_valid & frame_err}, 32'd0);
            if (exp_q.size() == 0) begin
               chk("unexpected_pulse", {30'd0, scan_valid, frame_err}, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("pulse_kind", {31'd0, frame_err}, {31'd0, e.is_err});
               chk("scan_code", {24'd0, scan_code}, {24'd0, e.code});
               @(negedge clk);
               chk("keys", {28'd0, up, down, right, left}, {28'd0, e.keys});
               chk("pulse_width", {30'd0, scan_valid, frame_err}, 32'd0);
            end
         end
      end
   end

   initial begin
      logic [7:0] pool[11];
      logic [7:0] b;
      int         r;
      pool = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h74, 8'h6B, 8'h1D, 8'h1B, 8'h23, 8'h1C, 8'h00};
      m_ext = 0; m_brk = 0; m_arrow = '0; m_letter = '0; m_last = 8'h00;

      // Reset held with a noisy bus: everything stays low.
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         ps2_clk  = 1'($urandom);
         ps2_data = 1'($urandom);
         @(negedge clk);
         chk("reset_outputs", {23'd0, scan_code, scan_valid, frame_err, up, down, right, left}, 32'd0);
      end
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      repeat (5) @(negedge clk);
      reset = 1'b1;
      repeat (50) @(negedge clk);

      send_frame(8'h75, 0, 0);                // no E0: up stays low
      send_seq(8'hE0, 8'h75, 8'h00, 2);       // up make
      send_seq(8'hE0, 8'hF0, 8'h75, 3);       // up break
      send_seq(8'hF0, 8'hE0, 8'h72, 3);       // reversed prefixes, down already low
      send_frame(8'h72, 1, 0);                // parity error
      send_frame(8'h5A, 0, 1);                // stop error

      // Partial frame: start + 5 data bits, then silence past the timeout.
      push_err();
      ps2_bit(1'b0);
      for (int i = 0; i < 5; i++) ps2_bit(1'($urandom));
      ps2_data = 1'b1;
      repeat (10100) @(negedge clk);
      send_seq(8'hE0, 8'h74, 8'h00, 2);       // right make

      send_seq(8'hE0, 8'h6B, 8'h00, 2);
      send_frame(8'h1C, 0, 0);
      send_seq(8'hF0, 8'h1C, 8'h00, 2);
      send_seq(8'hE0, 8'hF0, 8'h6B, 3);
      send_seq(8'hE0, 8'hE0, 8'h75, 3);       // repeated prefix
      send_seq(8'hE0, 8'h75, 8'h00, 2);       // typematic repeat

      // Prefix followed by an errored frame must drop the prefix.
      send_frame(8'hE0, 0, 0);
      send_frame(8'h11, 1, 0);
      send_frame(8'h72, 0, 0);

      for (int n = 0; n < 45; n++) begin
         r = int'($urandom_range(0, 99));
         b = (r < 80) ? pool[$urandom_range(0, 9)] : 8'($urandom);
         send_frame(b, r >= 80 && r < 90, r >= 95);
      end

      repeat (100) @(negedge clk);
      chk("queue_drained", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
